qconv_launcher: RTL and testbench

- Initiator side of the qconv_states start/finish handshake.
- Accepts a job command (number of passes) over a valid/ready interface.
- Fires one start pulse per pass toward qconv_states and waits for finish before starting the next pass.
- Enforces a watchdog timeout and reports done/error status to the layer controller.

---
 rtl/qconv_launcher_pkg.sv | 23 ++
 rtl/qconv_launcher_if.sv | 30 +++
 rtl/qconv_launcher_watchdog.sv | 32 +++
 rtl/qconv_launcher.sv | 128 ++++++++++++
 tb/tb_qconv_launcher.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qconv_launcher_pkg.sv
// Shared types and defaults for the qconv_states launcher.
//   launcher_state_t : launcher FSM states
//   pass_count_t     : pass count at the default width
//   Default*         : default parameter values for the launcher
package qconv_pkg;

    localparam int unsigned DefaultPassBitWidth    = 8;
    localparam int unsigned DefaultTimeoutBitWidth = 16;
    localparam int unsigned DefaultTimeoutCycles   = 10000;
    localparam int unsigned DefaultGapCycles       = 1;

    typedef logic [DefaultPassBitWidth-1:0] pass_count_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        GAP,
        DONE,
        ERR
    } launcher_state_t;

endpackage

// File: rtl/qconv_launcher_if.sv
// Command / start-finish / status bundle between the layer controller,
// the launcher and qconv_states.
//   master : layer controller + qconv_states side (drives command, finish, err_clear)
//   slave  : launcher side (drives cmd_ready, start and status)
interface qconv_launcher_if #(
    parameter int unsigned PassBitWidth = qconv_pkg::DefaultPassBitWidth
) ();

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [PassBitWidth-1:0] cmd_passes;
    logic                    start;
    logic                    finish;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic                    err_clear;
    logic [PassBitWidth-1:0] pass_count;

    modport master (
        output cmd_valid, cmd_passes, finish, err_clear,
        input  cmd_ready, start, busy, done, error, pass_count
    );

    modport slave (
        input  cmd_valid, cmd_passes, finish, err_clear,
        output cmd_ready, start, busy, done, error, pass_count
    );

endinterface

// File: rtl/qconv_launcher_watchdog.sv
// Clear/enable cycle counter with a terminal-count flag at TerminalCount-1.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable
//   tc_c     : count has reached TerminalCount-1
module qconv_watchdog #(
    parameter int unsigned Width         = qconv_pkg::DefaultTimeoutBitWidth,
    parameter int unsigned TerminalCount = qconv_pkg::DefaultTimeoutCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [Width-1:0] count;

    // Never overflows: the owner stops enabling once tc_c has been seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + Width'(1);
        end
    end

    assign tc_c = (count == Width'(TerminalCount - 1));

endmodule

// File: rtl/qconv_launcher.sv
// Initiator side of the qconv_states start/finish handshake. Accepts a job of
// N passes, fires one start pulse per pass, waits for finish between passes,
// and flags a sticky error if a pass exceeds the watchdog budget.
//   clk, rst : clock, async active-high reset
//   bus      : qconv_launcher_if.slave (command, start/finish, status)
module qconv_launcher
    import qconv_pkg::*;
#(
    parameter int unsigned PassBitWidth    = DefaultPassBitWidth,
    parameter int unsigned TimeoutBitWidth = DefaultTimeoutBitWidth,
    parameter int unsigned TimeoutCycles   = DefaultTimeoutCycles,
    parameter int unsigned GapCycles       = DefaultGapCycles
) (
    input  logic             clk,
    input  logic             rst,
    qconv_launcher_if.slave  bus
);

    localparam int unsigned GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;

    launcher_state_t         state, state_d;
    logic [PassBitWidth-1:0] passes_q, passes_d;
    logic [PassBitWidth-1:0] count_q, count_d;
    logic [GapW-1:0]         gap_q, gap_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    wd_tc;

    // Watchdog is cleared on entry to LAUNCH, so it measures cycles since start.
    qconv_watchdog #(
        .Width         (TimeoutBitWidth),
        .TerminalCount (TimeoutCycles)
    ) u_watchdog (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_d == LAUNCH),
        .en   ((state == LAUNCH) || (state == WAIT)),
        .tc_c (wd_tc)
    );

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            passes_q <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state    <= state_d;
            passes_q <= passes_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Next state; registered outputs are decoded from the next state so they
    // line up with the state they describe.
    always_comb begin
        state_d  = state;
        passes_d = passes_q;
        count_d  = count_q;
        gap_d    = gap_q;

        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    passes_d = bus.cmd_passes;
                    count_d  = '0;
                    state_d  = (bus.cmd_passes == '0) ? DONE : LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                // finish takes priority over a coincident timeout
                if (bus.finish) begin
                    count_d = count_q + PassBitWidth'(1);
                    if (count_d == passes_q) begin
                        state_d = DONE;
                    end else if (GapCycles == 0) begin
                        state_d = LAUNCH;
                    end else begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end else if (wd_tc) begin
                    state_d = ERR;
                end
            end
            GAP: begin
                if ((32'(gap_q) + 32'd1) >= GapCycles) begin
                    state_d = LAUNCH;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            DONE: state_d = IDLE;
            ERR: begin
                if (bus.err_clear) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        start_d = (state_d == LAUNCH);
        busy_d  = (state_d == LAUNCH) || (state_d == WAIT) || (state_d == GAP);
        done_d  = (state_d == DONE);
        error_d = (state_d == ERR);
    end

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.start      = start_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.pass_count = count_q;

endmodule

// File: tb/tb_qconv_launcher.sv
// Self-checking bench for qconv_launcher (TimeoutCycles=20, GapCycles=1).
module tb_qconv_launcher;
    import qconv_pkg::*;

    localparam int unsigned PassW   = 8;
    localparam int          Timeout = 20;
    localparam int          Gap     = 1;

    logic clk;
    logic rst;
    logic resp_finish;
    logic spur_finish;

    qconv_launcher_if #(.PassBitWidth(PassW)) bus ();

    qconv_launcher #(
        .PassBitWidth    (PassW),
        .TimeoutBitWidth (16),
        .TimeoutCycles   (Timeout),
        .GapCycles       (Gap)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.finish = resp_finish | spur_finish;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- timeline model ----------------
    // Tracks the job as cycle timestamps: when the next start is due, when the
    // outstanding pass started, when done is due.
    bit m_ready, m_busy, m_err, m_pending;
    int m_count, m_passes, launch_at, start_at, done_at;

    always @(posedge clk or posedge rst) begin
        int n;
        if (rst) begin
            m_ready = 1; m_busy = 0; m_err = 0; m_pending = 0;
            m_count = 0; m_passes = 0;
            launch_at = -1; start_at = -1; done_at = -1;
        end else begin
            n = cyc + 1;
            if (m_ready && bus.cmd_valid) begin
                m_count  = 0;
                m_passes = int'(bus.cmd_passes);
                if (m_passes == 0) done_at = n;
                else begin launch_at = n; m_busy = 1; end
            end else if (m_pending && cyc > start_at && bus.finish) begin
                m_pending = 0;
                m_count++;
                if (m_count == m_passes) begin done_at = n; m_busy = 0; end
                else launch_at = n + Gap;
            end else if (m_pending && (cyc - start_at) == Timeout - 1) begin
                m_pending = 0; m_err = 1; m_busy = 0;
            end else if (m_err && bus.err_clear) begin
                m_err = 0;
            end
            if (launch_at == n) begin start_at = n; m_pending = 1; end
            m_ready = !m_busy && !m_err && (done_at != n);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("cmd_ready",  int'(bus.cmd_ready),  int'(m_ready));
            check("start",      int'(bus.start),      int'(start_at == cyc));
            check("busy",       int'(bus.busy),       int'(m_busy));
            check("done",       int'(bus.done),       int'(done_at == cyc));
            check("error",      int'(bus.error),      int'(m_err));
            check("pass_count", int'(bus.pass_count), m_count);
        end
    end

    // ---------------- responder and monitors ----------------
    int resp_lat = -1;
    int finish_at = -1;
    int n_starts = 0;
    int n_dones  = 0;

    always @(negedge clk) begin
        if (rst) begin
            finish_at   = -1;
            resp_finish = 1'b0;
        end else begin
            resp_finish = (cyc == finish_at);
            if (bus.start && resp_lat >= 0) finish_at = cyc + resp_lat;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.start) n_starts++;
        if (!rst && bus.done)  n_dones++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_cmd(input int p, output int acc);
        bit took = 0;
        acc = -1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_passes = pass_count_t'(p);
        for (int t = 0; t < 50 && !took; t++) begin
            if (bus.cmd_ready) begin took = 1; acc = cyc; end
            tick();
        end
        bus.cmd_valid  = 1'b0;
        bus.cmd_passes = 8'hA5;
        if (!took) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_start(input int budget, output int at);
        at = -1;
        for (int t = 0; t < budget; t++) begin
            if (bus.start) begin at = cyc; return; end
            tick();
        end
        check("wait_start_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int t = 0; t < budget; t++) begin
            if (bus.done) begin at = cyc; return; end
            tick();
        end
        check("wait_done_timeout", 0, 1);
    endtask

    task automatic wait_error(input int budget, output int at);
        at = -1;
        for (int t = 0; t < budget; t++) begin
            if (bus.error) begin at = cyc; return; end
            tick();
        end
        check("wait_error_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $fatal(1, "bench timeout");
    end

    // ---------------- directed tests ----------------
    initial begin
        int acc, s1, s2, s3, dc, ec, s0, d0, sn;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_passes = '0; bus.err_clear = 1'b0;
        spur_finish = 1'b0;
        tick(); tick();
        check("rst_cmd_ready",  int'(bus.cmd_ready),  1);
        check("rst_start",      int'(bus.start),      0);
        check("rst_busy",       int'(bus.busy),       0);
        check("rst_done",       int'(bus.done),       0);
        check("rst_error",      int'(bus.error),      0);
        check("rst_pass_count", int'(bus.pass_count), 0);
        rst = 1'b0;
        tick();

        // 1: three passes, finish 5 cycles after each start
        resp_lat = 5; s0 = n_starts; d0 = n_dones;
        send_cmd(3, acc);
        wait_start(10, s1); check("t1_start_latency", s1 - acc, 1);
        tick(); wait_start(20, s2); check("t1_spacing_a", s2 - s1, 7);
        tick(); wait_start(20, s3); check("t1_spacing_b", s3 - s2, 7);
        tick(); wait_done(20, dc);  check("t1_done_at", dc - s3, 6);
        check("t1_pass_count", int'(bus.pass_count), 3);
        check("t1_model_count", m_count, 3);
        check("t1_error", int'(bus.error), 0);
        tick();
        check("t1_starts", n_starts - s0, 3);
        check("t1_dones", n_dones - d0, 1);

        // 2: zero-pass job
        s0 = n_starts;
        send_cmd(0, acc);
        wait_done(5, dc); check("t2_done_at", dc - acc, 1);
        check("t2_pass_count", int'(bus.pass_count), 0);
        tick();
        check("t2_ready", int'(bus.cmd_ready), 1);
        check("t2_no_start", n_starts - s0, 0);

        // 3: timeout, then recovery
        resp_lat = -1;
        send_cmd(2, acc);
        wait_start(5, s1);
        wait_error(40, ec); check("t3_error_at", ec - s1, 20);
        check("t3_busy", int'(bus.busy), 0);
        check("t3_ready", int'(bus.cmd_ready), 0);
        s0 = n_starts;
        bus.cmd_valid = 1'b1; bus.cmd_passes = 8'd1;
        repeat (5) tick();
        bus.cmd_valid = 1'b0;
        check("t3_sticky", int'(bus.error), 1);
        check("t3_cmd_ignored", n_starts - s0, 0);
        bus.err_clear = 1'b1; tick(); bus.err_clear = 1'b0;
        check("t3_cleared", int'(bus.error), 0);
        check("t3_ready_after_clear", int'(bus.cmd_ready), 1);
        bus.err_clear = 1'b1; tick(); bus.err_clear = 1'b0;
        check("t3_clear_in_idle", int'(bus.cmd_ready), 1);

        // 3b: finish on the last allowed cycle wins; one cycle later errors
        resp_lat = 19;
        send_cmd(1, acc);
        wait_done(40, dc); check("t3b_done_at", dc - (acc + 1), 20);
        check("t3b_no_error", int'(bus.error), 0);
        tick();
        resp_lat = 20;
        send_cmd(1, acc);
        wait_error(40, ec); check("t3b_error_at", ec - (acc + 1), 20);
        repeat (3) tick();
        bus.err_clear = 1'b1; tick(); bus.err_clear = 1'b0;
        tick();

        // 4: spurious finish in IDLE, LAUNCH and GAP
        resp_lat = 5; s0 = n_starts;
        spur_finish = 1'b1; tick(); spur_finish = 1'b0;
        check("t4_idle_ignored", int'(bus.cmd_ready), 1);
        send_cmd(2, acc);
        wait_start(5, s1);
        spur_finish = 1'b1; tick(); spur_finish = 1'b0;
        repeat (5) tick();
        spur_finish = 1'b1; tick(); spur_finish = 1'b0;
        wait_start(10, s2); check("t4_spacing", s2 - s1, 7);
        tick(); wait_done(20, dc);
        check("t4_pass_count", int'(bus.pass_count), 2);
        tick();
        check("t4_starts", n_starts - s0, 2);

        // 5: async reset during WAIT of pass 2 of 4
        send_cmd(4, acc);
        wait_start(5, s1);
        tick(); wait_start(20, s2);
        tick(); tick();
        check("t5_busy_before", int'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        check("t5_start_async", int'(bus.start), 0);
        check("t5_busy_async", int'(bus.busy), 0);
        check("t5_count_async", int'(bus.pass_count), 0);
        tick();
        rst = 1'b0;
        check("t5_ready", int'(bus.cmd_ready), 1);
        sn = n_starts;
        repeat (20) tick();
        check("t5_no_start", n_starts - sn, 0);

        // 6: back-to-back jobs with cmd_valid held
        resp_lat = 3; s0 = n_starts; d0 = n_dones;
        bus.cmd_valid = 1'b1; bus.cmd_passes = 8'd2;
        wait_done(60, dc);
        bus.cmd_passes = 8'd1;
        tick(); wait_start(5, s1); check("t6_b2b_start", s1 - dc, 2);
        tick(); wait_done(30, dc);
        bus.cmd_valid = 1'b0;
        check("t6_pass_count", int'(bus.pass_count), 1);
        repeat (3) tick();
        check("t6_starts", n_starts - s0, 3);
        check("t6_dones", n_dones - d0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
